// File: rtl/mips_regfile.sv
// 32 x DATA_W MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, $0 hardwired to zero, optional write-to-read bypass.
module mips_regfile #(
  parameter int unsigned        DATA_W  = 32,
  parameter bit                 BYPASS  = 1'b1,
  parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(32'h0000_7FFC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr1,
  input  logic [4:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              wr_ack
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned SP_IDX   = 29;

  // Index 0 has no storage; reads of $0 are forced to zero below.
  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
  logic              wr_ack_q;
  logic              wr_ack_d;
  logic              wr_commit;

  assign wr_commit = wr_en && (wr_addr != 5'd0);

  always_comb begin
    regs_d   = regs_q;
    wr_ack_d = 1'b0;
    if (wr_commit) begin
      regs_d[wr_addr] = wr_data;
      wr_ack_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= (i == int'(SP_IDX)) ? SP_INIT : '0;
      end
      wr_ack_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  // Read port 1: zero for $0, bypass a same-cycle write, else stored value.
  always_comb begin
    rd_data1 = '0;
    if (rd_addr1 != 5'd0) begin
      if (BYPASS && wr_en && (wr_addr == rd_addr1)) begin
        rd_data1 = wr_data;
      end else begin
        rd_data1 = regs_q[rd_addr1];
      end
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (rd_addr2 != 5'd0) begin
      if (BYPASS && wr_en && (wr_addr == rd_addr2)) begin
        rd_data2 = wr_data;
      end else begin
        rd_data2 = regs_q[rd_addr2];
      end
    end
  end

  assign wr_ack = wr_ack_q;

endmodule

// File: tb/tb_mips_regfile.sv
// Scoreboard bench for mips_regfile: a bypassing and a non-bypassing instance share
// stimulus; expected read/ack values come from an array model and are checked at negedge.
module tb_mips_regfile;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        ack_b, ack_n;

  mips_regfile #(.DATA_W(32), .BYPASS(1'b1), .SP_INIT(32'h0000_7FFC)) u_dut_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_b), .rd_data2(rd2_b),
    .wr_ack(ack_b)
  );

  mips_regfile #(.DATA_W(32), .BYPASS(1'b0), .SP_INIT(32'h0000_7FFC)) u_dut_nobyp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_n), .rd_data2(rd2_n),
    .wr_ack(ack_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1b;
    logic [31:0] r2b;
    logic [31:0] r1n;
    logic [31:0] r2n;
    logic        ack;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [32];
  logic        model_ack;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    model_mem[29] = 32'h0000_7FFC;
    model_ack     = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return model_mem[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // One clock cycle: drive inputs just after posedge, predict, then apply the edge to the model.
  task automatic step(input logic rst, input logic en, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    rst_n = rst; wr_en = en; wr_addr = wa; wr_data = wd; rd_addr1 = a1; rd_addr2 = a2;
    if (!rst) model_reset();
    e.r1b = model_read(a1, 1'b1);
    e.r2b = model_read(a2, 1'b1);
    e.r1n = model_read(a1, 1'b0);
    e.r2n = model_read(a2, 1'b0);
    e.ack = model_ack;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      model_ack = en && (wa != 5'd0);
      if (en && wa != 5'd0) model_mem[wa] = wd;
    end
    #1;
  endtask

  // Monitor: read ports are always presented; compare one entry per negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rd_data1_bypass", rd1_b, e.r1b);
        check("rd_data2_bypass", rd2_b, e.r2b);
        check("rd_data1_nobypass", rd1_n, e.r1n);
        check("rd_data2_nobypass", rd2_n, e.r2n);
        check("wr_ack_bypass", 32'(ack_b), 32'(e.ack));
        check("wr_ack_nobypass", 32'(ack_n), 32'(e.ack));
      end
    end
  end

  initial begin
    int wait_cyc;
    logic [4:0] wa, a1, a2;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset, then read every address on both ports.
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

    // Write reg 8, read it back; ack for exactly one cycle.
    step(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0);

    // Writes to $0 are dropped and never bypassed.
    step(1'b1, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Same-cycle bypass on both ports.
    step(1'b1, 1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd5);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

    // Asynchronous reset clears reg 31; a write during reset is discarded.
    step(1'b1, 1'b1, 5'd31, 32'h0000_00FF, 5'd31, 5'd29);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd29);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd29);
    step(1'b0, 1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd30);

    // Back-to-back writes to reg 3 while watching reg 3 and reg 4.
    step(1'b1, 1'b1, 5'd3, 32'd1, 5'd3, 5'd4);
    step(1'b1, 1'b1, 5'd3, 32'd2, 5'd3, 5'd4);
    step(1'b1, 1'b1, 5'd3, 32'd3, 5'd3, 5'd4);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);

    // Random traffic with frequent address collisions and occasional resets.
    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), wa, $urandom, a1, a2);
    end
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(negedge clk); #1;
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32 x 32-bit general-purpose register file for the MIPS datapath.
- Sits directly downstream of the 5-bit write-destination select mux. That mux chooses rt or rd, and its output drives wr_addr here.
- Provides two combinational read ports for the decode stage and one synchronous write port for write-back.
- Register $0 is hardwired to zero. Optional same-cycle write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data; 0 = the read returns the stored value.
- SP_INIT, 32'h0000_7FFC, reset value of register 29 ($sp). All other registers reset to 0.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable (RegWrite from control).
- wr_addr  input  5  write destination register; output of the rt/rd select mux.
- wr_data  input  DATA_W  write-back data.
- rd_addr1  input  5  read port 1 address (rs).
- rd_addr2  input  5  read port 2 address (rt).
- rd_data1  output  DATA_W  read port 1 data.
- rd_data2  output  DATA_W  read port 2 data.
- wr_ack  output  1  registered pulse; high for one cycle after a write is committed to a nonzero register.

Behaviour:
- Storage: 31 physical registers, indices 1..31. Index 0 is not stored.
- Reset (rst_n low, asynchronous, no clock needed):
  - Registers 1..28 and 30..31 become 0; register 29 becomes SP_INIT.
  - wr_ack becomes 0.
  - Reset overrides any write in progress; a write whose edge coincides with rst_n low is discarded.
  - Deassertion takes effect at the next rising edge.
- Write:
  - On a rising edge with rst_n high, wr_en = 1 and wr_addr != 0: reg[wr_addr] <= wr_data, and wr_ack <= 1 on that edge.
  - wr_en = 0 or wr_addr = 0: no state change, and wr_ack <= 0 on that edge.
  - Writes to $0 are silently dropped; no error output.
- Read (combinational, zero latency):
  - rd_addr = 0: rd_data = 0 always, including when a write to 0 is presented.
  - BYPASS = 1 and wr_en = 1 and wr_addr = rd_addr != 0: rd_data = wr_data in the same cycle. The decode stage can then read a value written back in that cycle.
  - Otherwise rd_data = reg[rd_addr].
  - Both ports apply these rules independently. Both ports may read the same address; both may bypass at once.
- During reset, rd_data reflects the reset register values. Bypass still applies if wr_en = 1.
- No X propagation: every register has a defined reset value, and wr_addr/rd_addr cover all 32 codes.
- Width: DATA_W applies to all data paths. Addresses are fixed at 5 bits.
- No internal pipelining.
  - Write latency: 1 clock. The new value is visible at the read ports the cycle after the edge, or the same cycle when BYPASS = 1.
  - Read latency: 0 clocks.

Test Plan:
- Reset then read all 32 addresses -> rd_data = 0 for every address except 29, which returns 32'h0000_7FFC; wr_ack = 0.
- Write 32'hDEAD_BEEF to reg 8 with wr_en = 1 -> next cycle rd_addr1 = 8 gives 32'hDEAD_BEEF; wr_ack is high for exactly one cycle.
- Write 32'h1234_5678 to reg 0 -> rd_data1 with rd_addr1 = 0 stays 0, both same-cycle and next cycle; wr_ack stays 0.
- BYPASS = 1: in one cycle, wr_en = 1, wr_addr = 5, wr_data = 32'hA5A5_A5A5, rd_addr1 = rd_addr2 = 5 -> both outputs equal 32'hA5A5_A5A5 before the edge. BYPASS = 0, same stimulus -> both return the old value (0) before the edge and 32'hA5A5_A5A5 after it.
- Write 32'h0000_00FF to reg 31, then pull rst_n low mid-cycle with no clock edge -> reg 31 reads 0 immediately. A write attempted while rst_n is low is not stored.
- Back-to-back writes to reg 3 (values 1, 2, 3) on consecutive edges, while reading reg 3 and reg 4 -> reg 3 tracks 1, 2, 3 cycle by cycle; reg 4 stays 0; wr_ack is high for three consecutive cycles.
